// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register; interrupt injection compiled in only with `FETCH_INT_EN.
// Latency: a one-byte op reaches ID one edge after its address is issued; two-byte ops add one bubble.
// Backpressure: !(pc_write_en & if_id_en) freezes PC, state and the ID register; flush overrides.
module fetch_stage #(
    parameter logic [7:0] INT_VEC_ADDR = 8'h01,
    parameter logic [7:0] BOOT_ADDR    = 8'h00,
    parameter logic [7:0] NOP_WORD     = 8'h00
) (
    input  logic       clk,
    input  logic       rstn,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_data,
    input  logic       pc_write_en,
    input  logic       if_id_en,
    input  logic       flush,
    input  logic [7:0] redirect_pc,
    input  logic       intr,
    output logic [7:0] id_ir,
    output logic [7:0] id_imm,
    output logic [7:0] id_pc_plus1,
    output logic       id_valid,
    output logic       id_is_int,
    output logic [7:0] pc
);

    typedef enum logic [1:0] {
        S_BOOT    = 2'd0,
        S_RUN     = 2'd1,
        S_IMM     = 2'd2,
        S_INT_VEC = 2'd3
    } state_t;

    state_t     r_state;
    logic [7:0] r_pc;
    logic [7:0] r_ir_hold;
    logic [7:0] r_id_ir;
    logic [7:0] r_id_imm;
    logic [7:0] r_id_pc_plus1;
    logic       r_id_valid;
    logic       r_id_is_int;

    logic       w_advance;
    logic       w_two_byte;
    logic       w_take_int;
    logic [7:0] w_pc_inc;

    assign w_advance  = pc_write_en & if_id_en;
    assign w_two_byte = (imem_data[7:4] == 4'hC);
    assign w_pc_inc   = r_pc + 8'd1;

`ifdef FETCH_INT_EN
    logic r_intr_q;
    logic r_pending;
    logic w_intr_rise;
    logic w_flush_vec;

    assign w_intr_rise = intr & ~r_intr_q;
    assign w_flush_vec = flush & (r_state == S_INT_VEC);
    assign w_take_int  = (r_state == S_RUN) & w_advance & ~flush & r_pending;

    // A flush that lands while the vector is being read cancels it, so re-arm the request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_intr_q  <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_intr_q <= intr;
            if (w_intr_rise || w_flush_vec) begin
                r_pending <= 1'b1;
            end else if (w_take_int) begin
                r_pending <= 1'b0;
            end
        end
    end
`else
    logic w_unused_intr;

    assign w_unused_intr = intr;
    assign w_take_int    = 1'b0;
`endif

    always_comb begin
        imem_addr = r_pc;
        case (r_state)
            S_BOOT:    imem_addr = BOOT_ADDR;
            S_INT_VEC: imem_addr = INT_VEC_ADDR;
            default:   imem_addr = r_pc;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= S_BOOT;
            r_pc          <= 8'h00;
            r_ir_hold     <= 8'h00;
            r_id_ir       <= NOP_WORD;
            r_id_imm      <= 8'h00;
            r_id_pc_plus1 <= 8'h00;
            r_id_valid    <= 1'b0;
            r_id_is_int   <= 1'b0;
        end else if (r_state == S_BOOT) begin
            r_pc        <= imem_data;
            r_state     <= S_RUN;
            r_id_ir     <= NOP_WORD;
            r_id_imm    <= 8'h00;
            r_id_valid  <= 1'b0;
            r_id_is_int <= 1'b0;
        end else if (flush) begin
            r_pc        <= redirect_pc;
            r_state     <= S_RUN;
            r_id_ir     <= NOP_WORD;
            r_id_imm    <= 8'h00;
            r_id_valid  <= 1'b0;
            r_id_is_int <= 1'b0;
        end else if (w_advance) begin
            case (r_state)
                S_RUN: begin
                    if (w_take_int) begin
                        // Return address is the instruction that was not fetched this cycle.
                        r_id_ir       <= NOP_WORD;
                        r_id_imm      <= 8'h00;
                        r_id_pc_plus1 <= r_pc;
                        r_id_valid    <= 1'b1;
                        r_id_is_int   <= 1'b1;
                        r_state       <= S_INT_VEC;
                    end else if (w_two_byte) begin
                        r_ir_hold   <= imem_data;
                        r_pc        <= w_pc_inc;
                        r_id_ir     <= NOP_WORD;
                        r_id_imm    <= 8'h00;
                        r_id_valid  <= 1'b0;
                        r_id_is_int <= 1'b0;
                        r_state     <= S_IMM;
                    end else begin
                        r_id_ir       <= imem_data;
                        r_id_imm      <= 8'h00;
                        r_id_pc_plus1 <= w_pc_inc;
                        r_id_valid    <= 1'b1;
                        r_id_is_int   <= 1'b0;
                        r_pc          <= w_pc_inc;
                    end
                end
                S_IMM: begin
                    r_id_ir       <= r_ir_hold;
                    r_id_imm      <= imem_data;
                    r_id_pc_plus1 <= w_pc_inc;
                    r_id_valid    <= 1'b1;
                    r_id_is_int   <= 1'b0;
                    r_pc          <= w_pc_inc;
                    r_state       <= S_RUN;
                end
                S_INT_VEC: begin
                    r_pc        <= imem_data;
                    r_id_ir     <= NOP_WORD;
                    r_id_imm    <= 8'h00;
                    r_id_valid  <= 1'b0;
                    r_id_is_int <= 1'b0;
                    r_state     <= S_RUN;
                end
                default: begin
                    r_state <= S_BOOT;
                end
            endcase
        end
    end

    assign id_ir       = r_id_ir;
    assign id_imm      = r_id_imm;
    assign id_pc_plus1 = r_id_pc_plus1;
    assign id_valid    = r_id_valid;
    assign id_is_int   = r_id_is_int;
    assign pc          = r_pc;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

`ifdef FETCH_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif
    localparam logic [7:0] BOOT_A = 8'h00;
    localparam logic [7:0] VEC_A  = 8'h01;
    localparam logic [7:0] NOP    = 8'h00;
    localparam int MB = 0, MR = 1, MI = 2, MV = 3;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] imem_addr, imem_data;
    logic       pc_write_en = 1'b1, if_id_en = 1'b1, flush = 1'b0, intr = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
    logic [7:0] id_ir, id_imm, id_pc_plus1, pc;
    logic       id_valid, id_is_int;

    logic [7:0] mem [256];
    assign imem_data = mem[imem_addr];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rstn(rstn), .imem_addr(imem_addr), .imem_data(imem_data),
        .pc_write_en(pc_write_en), .if_id_en(if_id_en), .flush(flush),
        .redirect_pc(redirect_pc), .intr(intr), .id_ir(id_ir), .id_imm(id_imm),
        .id_pc_plus1(id_pc_plus1), .id_valid(id_valid), .id_is_int(id_is_int), .pc(pc)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [41:0] dut_all();
        return {imem_addr, pc, id_ir, id_imm, id_pc_plus1, id_valid, id_is_int};
    endfunction

    function automatic logic [33:0] dut_id();
        return {pc, id_ir, id_imm, id_pc_plus1, id_valid, id_is_int};
    endfunction

    task automatic step(input logic pwe, input logic en, input logic fl,
                        input logic [7:0] rdr, input logic irq);
        @(negedge clk);
        pc_write_en = pwe; if_id_en = en; flush = fl; redirect_pc = rdr; intr = irq;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    int         m_mode;
    logic [7:0] m_pc, m_hold, m_ir, m_imm, m_pp1;
    logic       m_vld, m_int, m_pend, m_irq_prev;

    function automatic logic [7:0] model_addr();
        if (m_mode == MB) return BOOT_A;
        if (m_mode == MV) return VEC_A;
        return m_pc;
    endfunction

    function automatic logic [41:0] model_all();
        return {model_addr(), m_pc, m_ir, m_imm, m_pp1, m_vld, m_int};
    endfunction

    task automatic model_reset();
        m_mode = MB; m_pc = 0; m_hold = 0; m_ir = NOP; m_imm = 0; m_pp1 = 0;
        m_vld = 0; m_int = 0; m_pend = 0; m_irq_prev = 0;
    endtask

    task automatic set_id(input logic [7:0] ir, input logic [7:0] imm, input logic [7:0] pp1,
                          input logic v, input logic isint);
        m_ir = ir; m_imm = imm; m_pp1 = pp1; m_vld = v; m_int = isint;
    endtask

    task automatic bubble();
        m_ir = NOP; m_imm = 0; m_vld = 0; m_int = 0;
    endtask

    task automatic model_step(input bit pwe, input bit en, input bit fl,
                              input logic [7:0] rdr, input bit irq);
        logic [7:0] d;
        bit adv, rise, take, fvec;
        d = mem[model_addr()];
        adv = pwe & en;
        rise = INT_EN && irq && !m_irq_prev;
        take = 0; fvec = 0;
        if (m_mode == MB) begin
            m_pc = d; m_mode = MR; bubble();
        end else if (fl) begin
            fvec = (m_mode == MV); m_pc = rdr; m_mode = MR; bubble();
        end else if (adv) begin
            if (m_mode == MR && m_pend) begin
                take = 1; set_id(NOP, 8'h00, m_pc, 1'b1, 1'b1); m_mode = MV;
            end else if (m_mode == MR && d[7:4] == 4'hC) begin
                m_hold = d; m_pc = m_pc + 8'd1; bubble(); m_mode = MI;
            end else if (m_mode == MR) begin
                set_id(d, 8'h00, m_pc + 8'd1, 1'b1, 1'b0); m_pc = m_pc + 8'd1;
            end else if (m_mode == MI) begin
                set_id(m_hold, d, m_pc + 8'd1, 1'b1, 1'b0); m_pc = m_pc + 8'd1; m_mode = MR;
            end else begin
                m_pc = d; bubble(); m_mode = MR;
            end
        end
        if (take) m_pend = 0;
        if (fvec && INT_EN) m_pend = 1;
        if (rise) m_pend = 1;
        m_irq_prev = irq;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic       pwe, en, fl;
        logic [7:0] rdr;
        logic [7:0] e_pc, e_ir, e_imm, e_pp1;
        logic       e_vld;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input logic pwe, input logic en, input logic fl, input logic [7:0] rdr,
                                input logic [7:0] e_pc, input logic [7:0] e_ir, input logic [7:0] e_imm,
                                input logic [7:0] e_pp1, input logic e_vld);
        vec_t v;
        v.pwe = pwe; v.en = en; v.fl = fl; v.rdr = rdr;
        v.e_pc = e_pc; v.e_ir = e_ir; v.e_imm = e_imm; v.e_pp1 = e_pp1; v.e_vld = e_vld;
        return v;
    endfunction

    bit         do_rst;
    bit         s_pwe, s_en, s_fl, s_irq;
    logic [7:0] s_rdr;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h10; mem[8'h01] = 8'h80;
        mem[8'h10] = 8'h21; mem[8'h11] = 8'h35; mem[8'h12] = 8'h47; mem[8'h13] = 8'hC4;
        mem[8'h14] = 8'h55; mem[8'h15] = 8'h66; mem[8'h16] = 8'hC4; mem[8'h30] = 8'h12;
        mem[8'hFF] = 8'h2A; mem[8'h40] = 8'h33; mem[8'h41] = 8'hC7; mem[8'h42] = 8'h99;
        mem[8'h43] = 8'hC8; mem[8'h80] = 8'h5A;

        tbl[0]  = mk(1, 1, 0, 8'h00, 8'h11, 8'h21, 8'h00, 8'h11, 1);
        tbl[1]  = mk(1, 1, 0, 8'h00, 8'h12, 8'h35, 8'h00, 8'h12, 1);
        tbl[2]  = mk(1, 1, 0, 8'h00, 8'h13, 8'h47, 8'h00, 8'h13, 1);
        tbl[3]  = mk(1, 1, 0, 8'h00, 8'h14, 8'h00, 8'h00, 8'h13, 0);
        tbl[4]  = mk(1, 1, 0, 8'h00, 8'h15, 8'hC4, 8'h55, 8'h15, 1);
        tbl[5]  = mk(0, 1, 0, 8'h00, 8'h15, 8'hC4, 8'h55, 8'h15, 1);
        tbl[6]  = mk(1, 0, 0, 8'h00, 8'h15, 8'hC4, 8'h55, 8'h15, 1);
        tbl[7]  = mk(0, 1, 0, 8'h00, 8'h15, 8'hC4, 8'h55, 8'h15, 1);
        tbl[8]  = mk(1, 1, 0, 8'h00, 8'h16, 8'h66, 8'h00, 8'h16, 1);
        tbl[9]  = mk(1, 1, 0, 8'h00, 8'h17, 8'h00, 8'h00, 8'h16, 0);
        tbl[10] = mk(1, 1, 1, 8'h30, 8'h30, 8'h00, 8'h00, 8'h16, 0);
        tbl[11] = mk(1, 1, 0, 8'h00, 8'h31, 8'h12, 8'h00, 8'h31, 1);
        tbl[12] = mk(1, 1, 1, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h31, 0);
        tbl[13] = mk(1, 1, 0, 8'h00, 8'h00, 8'h2A, 8'h00, 8'h00, 1);
        tbl[14] = mk(1, 1, 0, 8'h00, 8'h01, 8'h10, 8'h00, 8'h01, 1);
        tbl[15] = mk(0, 1, 1, 8'h40, 8'h40, 8'h00, 8'h00, 8'h01, 0);
        tbl[16] = mk(1, 1, 0, 8'h00, 8'h41, 8'h33, 8'h00, 8'h41, 1);
        tbl[17] = mk(1, 1, 0, 8'h00, 8'h42, 8'h00, 8'h00, 8'h41, 0);
        tbl[18] = mk(0, 1, 0, 8'h00, 8'h42, 8'h00, 8'h00, 8'h41, 0);
        tbl[19] = mk(1, 1, 0, 8'h00, 8'h43, 8'hC7, 8'h99, 8'h43, 1);

        // reset and boot
        #12;
        check("reset_state", dut_all(), {BOOT_A, 8'h00, NOP, 8'h00, 8'h00, 1'b0, 1'b0});
        @(negedge clk); rstn = 1'b1;
        #1 check("boot_pre_edge", {imem_addr, id_valid}, {BOOT_A, 1'b0});
        @(posedge clk); #1;
        check("boot_pc", dut_id(), {8'h10, NOP, 8'h00, 8'h00, 1'b0, 1'b0});

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].pwe, tbl[i].en, tbl[i].fl, tbl[i].rdr, 1'b0);
            check($sformatf("vec%0d", i), dut_id(),
                  {tbl[i].e_pc, tbl[i].e_ir, tbl[i].e_imm, tbl[i].e_pp1, tbl[i].e_vld, 1'b0});
        end

        // asynchronous reset in the middle of a two-byte fetch
        step(1, 1, 0, 8'h00, 1'b0);
        check("imm_enter", {pc, id_valid}, {8'h44, 1'b0});
        #2 rstn = 1'b0;
        #1 check("async_reset", dut_all(), {BOOT_A, 8'h00, NOP, 8'h00, 8'h00, 1'b0, 1'b0});
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        check("reboot", {pc, id_valid}, {8'h10, 1'b0});

        // interrupt: single injection for a held level, second after fall/rise
        step(1, 1, 0, 8'h00, 1'b0);
        check("pre_int", {pc, id_ir}, {8'h11, 8'h21});
        step(1, 1, 0, 8'h00, 1'b1);
        check("int_edge", {pc, id_ir, id_is_int}, {8'h12, 8'h35, 1'b0});
        step(1, 1, 0, 8'h00, 1'b1);
        if (INT_EN) check("int_inject", dut_all(), {VEC_A, 8'h12, NOP, 8'h00, 8'h12, 1'b1, 1'b1});
        else        check("int_ignored", dut_id(), {8'h13, 8'h47, 8'h00, 8'h13, 1'b1, 1'b0});
        step(1, 1, 0, 8'h00, 1'b1);
        check("int_vec_bubble", {id_valid, id_is_int}, {1'b0, 1'b0});
        if (INT_EN) check("int_vec_pc", pc, 8'h80);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 8'h00, 1'b1);
            check($sformatf("held_intr%0d", i), id_is_int, 1'b0);
        end
        if (INT_EN) check("isr_progress", pc, 8'h84);
        step(1, 1, 0, 8'h00, 1'b0);
        step(1, 1, 0, 8'h00, 1'b1);
        step(1, 1, 0, 8'h00, 1'b1);
        check("reint", id_is_int, INT_EN);
        if (INT_EN) check("reint_ret", id_pc_plus1, 8'h86);

        // randomized run against the model
        @(negedge clk);
        rstn = 1'b0; intr = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            do_rst = ($urandom_range(0, 199) == 0);
            pc_write_en = ($urandom_range(0, 9) < 8);
            if_id_en    = ($urandom_range(0, 9) < 9);
            flush       = ($urandom_range(0, 12) == 0);
            redirect_pc = 8'($urandom);
            if ($urandom_range(0, 5) == 0) intr = ~intr;
            if (do_rst) begin
                rstn = 1'b0;
                #1;
                model_reset();
                check("rand_reset", dut_all(), model_all());
            end else begin
                rstn = 1'b1;
                #1 check("rand_addr", imem_addr, model_addr());
                s_pwe = pc_write_en; s_en = if_id_en; s_fl = flush; s_rdr = redirect_pc; s_irq = intr;
                @(posedge clk); #1;
                model_step(s_pwe, s_en, s_fl, s_rdr, s_irq);
                check($sformatf("rand_cyc%0d", c), dut_all(), model_all());
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 8-bit CPU. It owns the PC and drives instruction-memory port A. It assembles one- and two-byte instructions and injects interrupt pseudo-instructions, then presents a registered instruction word to decode, where the control unit, hazard unit and register file consume it. Stall and flush inputs come from the control/hazard logic, and redirects come from the branch logic.

## Interface
- `INT_VEC_ADDR`, default 8'h01: memory address holding the ISR entry point.
- `BOOT_ADDR`, default 8'h00: memory address holding the reset entry point.
- `NOP_WORD`, default 8'h00: instruction byte driven on bubbles.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous reset, active-low.
- `imem_addr` out 8: port A address (combinational from state/PC).
- `imem_data` in 8: port A read data, combinational, same cycle.
- `pc_write_en` in 1: PC advance enable (control AND hazard).
- `if_id_en` in 1: IF/ID register enable.
- `flush` in 1: squash IF/ID and redirect.
- `redirect_pc` in 8: new PC used when `flush`=1.
- `intr` in 1: external interrupt request, level.
- `id_ir` out 8: instruction byte to decode.
- `id_imm` out 8: second byte of a two-byte instruction (else 0).
- `id_pc_plus1` out 8: return address (PC of the next instruction).
- `id_valid` out 1: IF/ID holds a real instruction.
- `id_is_int` out 1: IF/ID holds an injected interrupt.
- `pc` out 8: current PC (debug/visibility).

## Operation
- States: BOOT, RUN, IMM, INT_VEC. Reset state is BOOT.
- `advance` = `pc_write_en` & `if_id_en`. Priority: flush > stall (!advance) > interrupt > fetch.
- **BOOT**
  - `imem_addr`=`BOOT_ADDR`.
  - On the next edge, PC<=`imem_data` and the state goes to RUN.
  - The ID register is held as a bubble. Stall does not apply in BOOT.
- **RUN**
  - `imem_addr`=PC.
  - One-byte opcode: `id_ir`<=`imem_data`, `id_imm`<=0, `id_pc_plus1`<=PC+1, `id_valid`<=1, PC<=PC+1.
  - Two-byte opcode (`imem_data[7:4]`==4'hC): `ir_hold`<=`imem_data`, PC<=PC+1, the ID register gets a bubble, and the state goes to IMM.
- **IMM**
  - `imem_addr`=PC.
  - `id_ir`<=`ir_hold`, `id_imm`<=`imem_data`, `id_pc_plus1`<=PC+1, `id_valid`<=1, PC<=PC+1, state goes to RUN.
- **Bubble:** `id_ir`=`NOP_WORD`, `id_imm`=0, `id_valid`=0, `id_is_int`=0. `id_pc_plus1` is unchanged.
- **Interrupt pending**
  - `pending` is set by a rising edge of `intr`, detected against a registered copy of `intr`.
  - `pending` is cleared when the interrupt is injected.
  - An edge that coincides with the injection re-sets `pending`.
- **Interrupt injection**
  - Taken only in RUN, with `advance`=1, no flush, and `pending`=1.
  - No fetch occurs that cycle.
  - `id_ir`<=`NOP_WORD`, `id_is_int`<=1, `id_valid`<=1, `id_pc_plus1`<=PC (the unfetched instruction), state goes to INT_VEC.
- **INT_VEC**
  - `imem_addr`=`INT_VEC_ADDR`.
  - PC<=`imem_data`, the ID register gets a bubble, state goes to RUN.
  - INT_VEC holds during a stall.
- **Flush (any state except BOOT)**
  - ID register gets a bubble, PC<=`redirect_pc`, state goes to RUN.
  - A half-fetched two-byte instruction is abandoned.
  - Flush in INT_VEC re-sets `pending` so the interrupt is re-taken.
- **Stall:** PC, state, `ir_hold` and the ID register all hold. `pending` still latches new edges.
- **PC arithmetic:** 8-bit, wraps 8'hFF→8'h00. `id_pc_plus1` wraps identically.

## Timing
- Reset (asynchronous, any cycle) clears PC, the ID registers, `ir_hold`, `id_is_int`, `id_valid`, `pending` and the `intr` history to 0, and forces BOOT.
- After reset: `id_valid`=0, `id_ir`=`NOP_WORD`, `id_imm`=0, `pc`=0.
- Boot latency: PC holds M[`BOOT_ADDR`] one edge after `rstn` deasserts.
- One-byte instruction: visible in ID one edge after its address is on `imem_addr`. Throughput is 1 per cycle.
- Two-byte instruction: one bubble cycle, then visible in ID for exactly one cycle (absent stall).
- Interrupt: `intr` rising edge at edge N sets `pending`. Injection occurs at the first eligible edge ≥N+1. PC=M[`INT_VEC_ADDR`] one edge after injection.
- `intr` held high generates a single request. It must fall and rise again for another.

## Configuration
- `FETCH_INT_EN` defined: interrupt edge detect, `pending` and the INT_VEC state are compiled in as described above.
- `FETCH_INT_EN` undefined: `intr` is ignored, `id_is_int` is tied to 0, and INT_VEC is unreachable/absent. All other behaviour is identical.

## Test plan
- **Boot:** M[0]=8'h10, release `rstn` → `pc`=8'h10 after 1 edge, `id_valid`=0 before that edge.
- **One-byte stream:** M[10..12]=8'h21,8'h35,8'h47 → `id_ir` = 21,35,47 on consecutive cycles, `id_pc_plus1` = 11,12,13.
- **Two-byte instruction:** M[10]=8'hC4, M[11]=8'h55 → one bubble, then `id_ir`=C4, `id_imm`=55, `id_pc_plus1`=12, `id_valid`=1, `pc`=12.
- **Interrupt:** M[1]=8'h80, `intr` pulse while `pc`=8'h14 → `id_is_int`=1 with `id_pc_plus1`=14, then `pc`=80. A held `intr` gives no second injection.
- **Flush during IMM:** fetch 8'hC4 at 10, then `flush`=1 with `redirect_pc`=8'h30 → bubble, `pc`=30, state RUN, C4 never reaches `id_valid`=1.
- **Stall and wrap:**
  - `pc_write_en`=0 for 3 cycles → `pc` and `id_*` frozen.
  - With `pc`=8'hFF and a one-byte op → `pc`=00 and `id_pc_plus1`=00.
  - `rstn` low mid-IMM → immediate BOOT and all outputs at reset values.
